// File: rtl/alu_seq32_pkg.sv
// Shared definitions for the byte-serial ALU controller: control codes, alu8 operation
// encodings, controller states and the control-code decoder.
package alu_seq32_pkg;

    localparam logic [3:0] CtrlAnd = 4'b0000;
    localparam logic [3:0] CtrlOr  = 4'b0001;
    localparam logic [3:0] CtrlAdd = 4'b0010;
    localparam logic [3:0] CtrlSub = 4'b0110;
    localparam logic [3:0] CtrlSlt = 4'b0111;
    localparam logic [3:0] CtrlNor = 4'b1100;

    localparam logic [1:0] OpAnd  = 2'b00;
    localparam logic [1:0] OpOr   = 2'b01;
    localparam logic [1:0] OpSum  = 2'b10;
    localparam logic [1:0] OpLess = 2'b11;

    typedef enum logic [1:0] {StIdle, StByte, StSltFix, StDone} state_e;

    typedef struct packed {
        logic       a_invert;
        logic       b_invert;
        logic [1:0] operation;
    } alu8_drive_t;

    function automatic logic is_legal(input logic [3:0] ctrl);
        case (ctrl)
            CtrlAnd, CtrlOr, CtrlAdd, CtrlSub, CtrlSlt, CtrlNor: is_legal = 1'b1;
            default:                                             is_legal = 1'b0;
        endcase
    endfunction

    function automatic alu8_drive_t decode_ctrl(input logic [3:0] ctrl);
        case (ctrl)
            CtrlOr:           decode_ctrl = '{a_invert: 1'b0, b_invert: 1'b0, operation: OpOr};
            CtrlAdd:          decode_ctrl = '{a_invert: 1'b0, b_invert: 1'b0, operation: OpSum};
            CtrlSub, CtrlSlt: decode_ctrl = '{a_invert: 1'b0, b_invert: 1'b1, operation: OpSum};
            // NOR via De Morgan: ~a & ~b
            CtrlNor:          decode_ctrl = '{a_invert: 1'b1, b_invert: 1'b1, operation: OpAnd};
            default:          decode_ctrl = '{a_invert: 1'b0, b_invert: 1'b0, operation: OpAnd};
        endcase
    endfunction

endpackage

// File: rtl/alu_seq32_alu8.sv
// Shared 8-bit ALU slice: eight ripple-carry alu_top bit cells with invert controls, a less
// input on bit 0, and MSB overflow/set outputs.
module alu_seq32_alu8
    import alu_seq32_pkg::*;
(
    input  logic [7:0] src1,
    input  logic [7:0] src2,
    input  logic       a_invert,
    input  logic       b_invert,
    input  logic       cin,
    input  logic       less,
    input  logic [1:0] operation,
    output logic [7:0] result,
    output logic       cout,
    output logic       overflow,
    output logic       set
);

    logic [8:0] carry;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;

    assign carry[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_slice
        assign a[i]       = a_invert ? ~src1[i] : src1[i];
        assign b[i]       = b_invert ? ~src2[i] : src2[i];
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end

    always_comb begin
        result = '0;
        case (operation)
            OpAnd:   result = a & b;
            OpOr:    result = a | b;
            OpSum:   result = sum;
            OpLess:  result = {7'b0, less};
            default: result = '0;
        endcase
    end

    assign cout     = carry[8];
    assign overflow = carry[7] ^ carry[8];
    // Signed less-than of the pass: sign corrected by overflow
    assign set      = sum[7] ^ overflow;

endmodule

// File: rtl/alu_seq32.sv
// Byte-serial W-bit ALU controller: sequences one alu8 over N_BYTES passes, chains carry,
// derives flags, and runs an extra pass to materialise set-less-than.
module alu_seq32
    import alu_seq32_pkg::*;
#(
    parameter int unsigned N_BYTES = 4,
    localparam int unsigned W = 8 * N_BYTES
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [3:0]   ctrl_i,
    input  logic [W-1:0] src1_i,
    input  logic [W-1:0] src2_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic [W-1:0] result_o,
    output logic         zero_o,
    output logic         cout_o,
    output logic         overflow_o,
    output logic         illegal_o
);

    localparam int unsigned IdxW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [W-1:0]    src1_q, src1_d;
    logic [W-1:0]    src2_q, src2_d;
    logic [3:0]      ctrl_q, ctrl_d;
    logic [W-1:0]    result_q, result_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            less_q, less_d;
    logic            illegal_q, illegal_d;

    alu8_drive_t drive;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_cin;
    logic        alu_less;
    logic [7:0]  alu_result;
    logic        alu_cout;
    logic        alu_ovf;
    logic        alu_set;
    logic        last_byte;
    logic        is_add_sub;
    logic        is_arith;

    assign last_byte  = (idx_q == IdxW'(N_BYTES - 1));
    assign is_add_sub = (ctrl_q == CtrlAdd) || (ctrl_q == CtrlSub);
    assign is_arith   = is_add_sub || (ctrl_q == CtrlSlt);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        ctrl_d    = ctrl_q;
        result_d  = result_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        less_d    = less_q;
        illegal_d = illegal_q;

        drive    = decode_ctrl(ctrl_q);
        alu_a    = src1_q[8*idx_q +: 8];
        alu_b    = src2_q[8*idx_q +: 8];
        alu_cin  = (idx_q == '0) ? drive.b_invert : carry_q;
        alu_less = 1'b0;

        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    src1_d    = src1_i;
                    src2_d    = src2_i;
                    ctrl_d    = ctrl_i;
                    idx_d     = '0;
                    result_d  = '0;
                    carry_d   = 1'b0;
                    cout_d    = 1'b0;
                    ovf_d     = 1'b0;
                    less_d    = 1'b0;
                    illegal_d = ~is_legal(ctrl_i);
                    state_d   = is_legal(ctrl_i) ? StByte : StDone;
                end
            end
            StByte: begin
                result_d[8*idx_q +: 8] = alu_result;
                carry_d = alu_cout;
                idx_d   = idx_q + 1'b1;
                if (last_byte) begin
                    cout_d  = is_arith & alu_cout;
                    ovf_d   = is_add_sub & alu_ovf;
                    less_d  = alu_set;
                    state_d = (ctrl_q == CtrlSlt) ? StSltFix : StDone;
                end
            end
            StSltFix: begin
                // Route the latched less bit through the alu8 less path into bit 0
                drive    = '{a_invert: 1'b0, b_invert: 1'b0, operation: OpLess};
                alu_a    = '0;
                alu_b    = '0;
                alu_cin  = 1'b0;
                alu_less = less_q;
                result_d = {{(W-1){1'b0}}, alu_result[0]};
                state_d  = StDone;
            end
            StDone: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            ctrl_q    <= '0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            less_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            ctrl_q    <= ctrl_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            less_q    <= less_d;
            illegal_q <= illegal_d;
        end
    end

    alu_seq32_alu8 u_alu8 (
        .src1      (alu_a),
        .src2      (alu_b),
        .a_invert  (drive.a_invert),
        .b_invert  (drive.b_invert),
        .cin       (alu_cin),
        .less      (alu_less),
        .operation (drive.operation),
        .result    (alu_result),
        .cout      (alu_cout),
        .overflow  (alu_ovf),
        .set       (alu_set)
    );

    assign req_ready_o = (state_q == StIdle);
    assign rsp_valid_o = (state_q == StDone);
    assign result_o    = result_q;
    // Zero is only meaningful once the full result is present
    assign zero_o      = rsp_valid_o & (result_q == '0);
    assign cout_o      = cout_q;
    assign overflow_o  = ovf_q;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_alu_seq32.sv
// Scoreboard bench for alu_seq32: directed operations push expected responses, a negedge
// monitor checks latency, hold-while-stalled and final values on each accepted response.
module tb_alu_seq32;

    logic        clk;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  ctrl_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic        cout_o;
    logic        overflow_o;
    logic        illegal_o;

    alu_seq32 #(.N_BYTES(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .ctrl_i      (ctrl_i),
        .src1_i      (src1_i),
        .src2_i      (src2_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .result_o    (result_o),
        .zero_o      (zero_o),
        .cout_o      (cout_o),
        .overflow_o  (overflow_o),
        .illegal_o   (illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] result;
        logic        zero;
        logic        cout;
        logic        ovf;
        logic        ill;
        int unsigned lat;
        int unsigned t_acc;
    } exp_t;

    exp_t sb[$];
    int   n_tests;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {31'b0, req_ready_o}, 32'd1);
        check({tag, "_rsp_valid"}, {31'b0, rsp_valid_o}, 32'd0);
        check({tag, "_result"}, result_o, 32'd0);
        check({tag, "_flags"}, {28'b0, zero_o, cout_o, overflow_o, illegal_o}, 32'd0);
    endtask

    // Issue at a negedge where the DUT is ready; the following posedge accepts.
    task automatic issue(input string name, input logic [3:0] ctrl, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic z,
                         input logic c, input logic o, input logic il, input int unsigned lat,
                         input bit track);
        exp_t e;
        int   k;
        k = 0;
        @(negedge clk);
        while (!req_ready_o && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready_o) begin
            check({name, "_ready_timeout"}, 32'd0, 32'd1);
            return;
        end
        e.name = name; e.result = res; e.zero = z; e.cout = c; e.ovf = o; e.ill = il;
        e.lat = lat; e.t_acc = cyc + 1;
        if (track) sb.push_back(e);
        req_valid_i = 1'b1;
        ctrl_i      = ctrl;
        src1_i      = a;
        src2_i      = b;
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    // Monitor
    bit          seen;
    bit          expect_idle;
    logic [35:0] snap;
    exp_t        cur;

    always @(negedge clk) begin
        #1;
        if (rst_i) begin
            seen        = 1'b0;
            expect_idle = 1'b0;
        end else begin
            if (expect_idle) begin
                check("idle_after_ack", {30'b0, rsp_valid_o, req_ready_o}, 32'd1);
                expect_idle = 1'b0;
            end
            if (rsp_valid_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", {31'b0, rsp_valid_o}, 32'd0);
                end else begin
                    cur = sb[0];
                    check({cur.name, "_busy_in_done"}, {31'b0, req_ready_o}, 32'd0);
                    if (!seen) begin
                        seen = 1'b1;
                        snap = {result_o, zero_o, cout_o, overflow_o, illegal_o};
                        check({cur.name, "_latency"}, cyc - cur.t_acc + 1, cur.lat);
                    end else begin
                        check({cur.name, "_hold_result"}, result_o, snap[35:4]);
                        check({cur.name, "_hold_flags"},
                              {28'b0, zero_o, cout_o, overflow_o, illegal_o}, {28'b0, snap[3:0]});
                    end
                    if (rsp_ready_i) begin
                        void'(sb.pop_front());
                        check({cur.name, "_result"}, result_o, cur.result);
                        check({cur.name, "_zero"}, {31'b0, zero_o}, {31'b0, cur.zero});
                        check({cur.name, "_cout"}, {31'b0, cout_o}, {31'b0, cur.cout});
                        check({cur.name, "_ovf"}, {31'b0, overflow_o}, {31'b0, cur.ovf});
                        check({cur.name, "_illegal"}, {31'b0, illegal_o}, {31'b0, cur.ill});
                        seen        = 1'b0;
                        expect_idle = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int k;
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        ctrl_i      = 4'b0000;
        src1_i      = '0;
        src2_i      = '0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        check_reset_outputs("reset");

        //     name        ctrl     src1          src2          result        z  c  o  il lat
        issue("add_ovf",   4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1, 0, 5, 1);
        issue("sub_zero",  4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1, 1, 0, 0, 5, 1);
        issue("slt_neg",   4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 1, 0, 0, 6, 1);
        issue("slt_ovf",   4'b0111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1, 0, 0, 0, 6, 1);
        issue("slt_ge",    4'b0111, 32'h00000005, 32'h00000003, 32'h00000000, 1, 1, 0, 0, 6, 1);
        issue("nor_zero",  4'b1100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0, 0, 5, 1);
        issue("and_mask",  4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 0, 5, 1);
        issue("or_merge",  4'b0001, 32'h12340000, 32'h00005678, 32'h12345678, 0, 0, 0, 0, 5, 1);
        issue("add_wrap",  4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 0, 0, 5, 1);
        issue("sub_under", 4'b0110, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 0, 0, 0, 0, 5, 1);
        issue("sub_ovf",   4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1, 1, 0, 5, 1);
        issue("ill_1111",  4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1, 0, 0, 1, 1, 1);

        // Backpressure: consumer stalls for three DONE cycles
        @(negedge clk);
        rsp_ready_i = 1'b0;
        issue("bp_add",    4'b0010, 32'h000000FF, 32'h00000001, 32'h00000100, 0, 0, 0, 0, 5, 1);
        k = 0;
        while (!rsp_valid_o && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("bp_valid_seen", {31'b0, rsp_valid_o}, 32'd1);
        repeat (3) @(negedge clk);
        rsp_ready_i = 1'b1;

        // Reset while byte 2 of an ADD is being processed
        issue("rst_add",   4'b0010, 32'h11111111, 32'h22222222, 32'h33333333, 0, 0, 0, 0, 5, 0);
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check_reset_outputs("mid_reset");
        repeat (8) @(negedge clk);
        check("mid_reset_no_rsp", {30'b0, rsp_valid_o, req_ready_o}, 32'd1);

        issue("ill_0101",  4'b0101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1, 0, 0, 1, 1, 1);

        k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("drain_pending", sb.size(), 32'd0);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
